// File: rtl/neuron_mac_fix.sv
// Streaming fixed-point MAC neuron: bias + sum(x*wgt) over N beats with
// symmetric per-step saturation, registered result through valid/ready.
module neuron_mac_fix #(
    parameter int W    = 16,
    parameter int F    = 8,
    parameter int N    = 784,
    parameter int RELU = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] wgt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] acc_out,
    output logic                busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Symmetric range: the most-negative code is never produced.
    localparam logic signed [W-1:0]   SMAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   SMIN    = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic signed [2*W-1:0] PMAX    = {{W{1'b0}}, SMAX};
    localparam logic signed [2*W-1:0] PMIN    = {{W{1'b1}}, SMIN};
    localparam logic signed [W:0]     SUM_MAX = {1'b0, SMAX};
    localparam logic signed [W:0]     SUM_MIN = {1'b1, SMIN};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [W-1:0]   out_q, out_d;

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] q_full;
    logic signed [W-1:0]   q_sat;
    logic signed [W:0]     sum_full;
    logic signed [W-1:0]   sum_sat;
    logic signed [W-1:0]   bias_sat;
    logic signed [W-1:0]   relu_v;

    // Per-beat datapath: floor-shifted product, clamp, widened add, clamp.
    always_comb begin
        prod   = x * wgt;
        q_full = prod >>> F;
        if (q_full > PMAX) begin
            q_sat = SMAX;
        end else if (q_full < PMIN) begin
            q_sat = SMIN;
        end else begin
            q_sat = q_full[W-1:0];
        end

        sum_full = {acc_q[W-1], acc_q} + {q_sat[W-1], q_sat};
        if (sum_full > SUM_MAX) begin
            sum_sat = SMAX;
        end else if (sum_full < SUM_MIN) begin
            sum_sat = SMIN;
        end else begin
            sum_sat = sum_full[W-1:0];
        end

        bias_sat = (bias < SMIN) ? SMIN : bias;
        relu_v   = ((RELU != 0) && sum_sat[W-1]) ? '0 : sum_sat;
    end

    // Handshakes: a beat transfers on an edge where in_valid & in_ready,
    // a result where out_valid & out_ready; valid never waits on ready.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = bias_sat;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = sum_sat;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        out_d   = relu_v;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign acc_out   = out_q;

endmodule

// File: tb/tb_neuron_mac_fix.sv
// Directed bench for neuron_mac_fix (N=4): vector table plus hand sequences
// for stalls, output back-pressure and asynchronous reset mid-vector.
module tb_neuron_mac_fix;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] bias = '0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] x = '0;
    logic signed [W-1:0] wgt = '0;
    logic                out_ready = 1'b0;

    logic                in_ready, out_valid, busy;
    logic signed [W-1:0] acc_out;
    logic                r_in_ready, r_out_valid, r_busy;
    logic signed [W-1:0] r_acc_out;

    always #5 clk = ~clk;

    neuron_mac_fix #(.W(16), .F(8), .N(4), .RELU(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .wgt(wgt),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .busy(busy)
    );

    neuron_mac_fix #(.W(16), .F(8), .N(4), .RELU(1)) u_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(r_in_ready), .x(x), .wgt(wgt),
        .out_valid(r_out_valid), .out_ready(out_ready), .acc_out(r_acc_out),
        .busy(r_busy)
    );

    typedef struct {
        logic signed [W-1:0] bias;
        logic signed [W-1:0] x;
        logic signed [W-1:0] wgt;
        logic signed [W-1:0] exp_o;
        logic signed [W-1:0] exp_r;
    } vec_t;

    vec_t                vecs[7];
    logic signed [W-1:0] beat_x[4];
    logic signed [W-1:0] beat_w[4];
    int                  n_vec = 0;
    int                  n_err = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input string name, input logic signed [W-1:0] b,
                           input logic signed [W-1:0] exp_o,
                           input logic signed [W-1:0] exp_r);
        @(posedge clk); #1;
        bias  = b;
        start = 1'b1;
        @(negedge clk);
        check({name, " busy_idle"}, busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({name, " in_ready"}, in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x        = beat_x[i];
            wgt      = beat_w[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check({name, " out_valid"}, out_valid, 1);
        check({name, " in_ready_done"}, in_ready, 0);
        check({name, " acc_out"}, acc_out, exp_o);
        check({name, " relu_acc_out"}, r_acc_out, exp_r);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, " out_valid_drop"}, out_valid, 0);
        check({name, " busy_drop"}, busy, 0);
        check({name, " acc_out_hold"}, acc_out, exp_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                  k;
        logic [6:0]          pat;
        logic signed [W-1:0] hs_sum;

        //          bias     x        wgt     exp_o    exp_r
        vecs[0] = '{16'sd0,      16'sd256,    16'sd512,   16'sd2048,   16'sd2048};
        vecs[1] = '{16'sd32000,  16'sd32767,  16'sd32767, 16'sd32767,  16'sd32767};
        vecs[2] = '{16'sd0,     -16'sd256,    16'sd256,  -16'sd1024,   16'sd0};
        vecs[3] = '{16'sd0,     -16'sd32767,  16'sd32767,-16'sd32767,  16'sd0};
        vecs[4] = '{16'sd0,      16'sd1,     -16'sd1,    -16'sd4,      16'sd0};
        vecs[5] = '{16'sd0,      16'sd1,      16'sd1,     16'sd0,      16'sd0};
        vecs[6] = '{-16'sd32768, 16'sd0,      16'sd0,    -16'sd32767,  16'sd0};

        // Reset state
        #12;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst acc_out", acc_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) begin
                beat_x[i] = vecs[v].x;
                beat_w[i] = vecs[v].wgt;
            end
            run_vec($sformatf("vec%0d", v), vecs[v].bias, vecs[v].exp_o, vecs[v].exp_r);
        end

        // Saturation is per step: clamp high on beat 0, then pull back down.
        beat_x[0] = 16'sd256;
        beat_w[0] = 16'sd256;
        for (int i = 1; i < 4; i++) begin
            beat_x[i] = -16'sd256;
            beat_w[i] = 16'sd256;
        end
        run_vec("nonsticky", 16'sd32767, 16'sd31999, 16'sd31999);

        // Stalled input stream with start pulsed mid-vector, then back-pressure.
        @(posedge clk); #1;
        bias  = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pat = 7'b1011001;
        k   = 0;
        hs_sum = '0;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            x        = 16'sd256;
            wgt      = pat[i] ? 16'(k + 1) : 16'sd77;
            start    = (i == 2);
            if (pat[i]) begin
                hs_sum = hs_sum + 16'(k + 1);
                k++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        wgt      = 16'sd100;
        start    = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("hs out_valid c%0d", j), out_valid, 1);
            check($sformatf("hs acc_out c%0d", j), acc_out, hs_sum);
            check($sformatf("hs in_ready c%0d", j), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("hs busy_after", busy, 0);
        check("hs out_valid_after", out_valid, 0);
        check("hs acc_out_hold", acc_out, 10);
        check("hs relu_acc_out", r_acc_out, 10);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Asynchronous reset between edges after two accepted beats.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x        = 16'sd256;
        wgt      = 16'sd256;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst in_ready", in_ready, 0);
        check("arst busy", busy, 0);
        check("arst out_valid", out_valid, 0);
        check("arst acc_out", acc_out, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat_x[i] = 16'sd256;
            beat_w[i] = 16'sd256;
        end
        run_vec("post_rst", 16'sd256, 16'sd1280, 16'sd1280);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
